// File: rtl/cla_alu_seq.sv
// cla_alu_seq: multi-cycle ADD/SUB/ADC/SBB unit, one carry-lookahead slice per cycle,
// with the inter-slice carry held in a register and status flags on the final slice.
module cla_alu_seq #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             ready
);
  localparam int NSLICE = WIDTH / BLOCK;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic r_carry;
  logic [WIDTH-1:0] r_a, r_b, w_out;
  logic [BLOCK-1:0] w_sa, w_sb, w_g, w_p, w_sum;
  logic [BLOCK:0] w_c;
  logic w_accept, w_last;
  assign w_accept = en && r_state != CALC;
  assign w_last = r_idx == IW'(NSLICE - 1);
  assign busy = r_state == CALC;
  assign ready = r_state == DONE;
  assign w_sa = r_a[r_idx*BLOCK +: BLOCK];
  assign w_sb = r_b[r_idx*BLOCK +: BLOCK];
  assign w_g = w_sa & w_sb;
  assign w_p = w_sa ^ w_sb;
  assign w_sum = w_p ^ w_c[BLOCK-1:0];
  // Each slice carry is a flat sum of generate terms, not a ripple through lower carries.
  always_comb begin
    logic acc, pp;
    acc = 1'b0;
    pp = 1'b0;
    w_c = '0;
    w_c[0] = r_carry;
    for (int k = 0; k < BLOCK; k++) begin
      acc = w_g[k];
      pp = w_p[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & w_g[j]);
        pp = pp & w_p[j];
      end
      w_c[k+1] = acc | (pp & r_carry);
    end
  end
  always_comb begin
    w_out = Output;
    w_out[r_idx*BLOCK +: BLOCK] = w_sum;
  end
  always_comb begin
    w_next = w_accept ? CALC : (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_carry <= 1'b0;
      r_idx <= '0;
      Output <= '0;
      c_out <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_a <= A;
      r_b <= mode[0] ? ~B : B;
      r_carry <= mode[1] ? (c_in ^ mode[0]) : mode[0];
      r_idx <= '0;
    end else if (r_state == CALC) begin
      Output <= w_out;
      r_carry <= w_c[BLOCK];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        c_out <= w_c[BLOCK];
        overflow <= w_c[BLOCK] ^ w_c[BLOCK-1];
        zero <= ~|w_out;
        negative <= w_out[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_cla_alu_seq.sv
// tb_cla_alu_seq: random and directed operations on 8-bit and 16-bit instances,
// checked against an integer-arithmetic model of add/subtract with carry and borrow.
module tb_cla_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic en = 1'b0, c_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] A = '0, B = '0, out;
  logic c_out, zero, negative, overflow, busy, ready;
  logic en16 = 1'b0, c16 = 1'b0;
  logic [1:0] mode16 = 2'd0;
  logic [15:0] A16 = '0, B16 = '0, out16;
  logic c_out16, zero16, negative16, overflow16, busy16, ready16;
  int n_cmp = 0, n_bad = 0, ncyc = 0;
  typedef struct {longint res; logic co, z, n, ov; int cyc;} exp_t;
  exp_t q[$];
  exp_t ce;

  cla_alu_seq #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .c_in(c_in), .A(A), .B(B),
    .Output(out), .c_out(c_out), .zero(zero), .negative(negative),
    .overflow(overflow), .busy(busy), .ready(ready));

  cla_alu_seq #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .mode(mode16), .c_in(c16), .A(A16), .B(B16),
    .Output(out16), .c_out(c_out16), .zero(zero16), .negative(negative16),
    .overflow(overflow16), .busy(busy16), .ready(ready16));

  // Exact integer arithmetic: carry = unsigned sum leaves range, no-borrow = difference >= 0,
  // overflow = signed result leaves the signed range.
  function automatic exp_t model(int w, logic [1:0] m, longint a, longint b, logic ci);
    exp_t e;
    longint mx = longint'(1) << w;
    longint sa = a >= mx / 2 ? a - mx : a;
    longint sb = b >= mx / 2 ? b - mx : b;
    longint k = longint'(m[1] & ci);
    longint u, s;
    if (!m[0]) begin
      u = a + b + k;
      s = sa + sb + k;
      e.co = u >= mx;
      e.res = u % mx;
    end else begin
      u = a - b - k;
      s = sa - sb - k;
      e.co = u >= 0;
      e.res = (u + mx) % mx;
    end
    e.ov = s < -(mx / 2) || s >= mx / 2;
    e.z = e.res == 0;
    e.n = e.res >= mx / 2;
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(longint o, logic co, logic z, logic n, logic ov);
    chk("lit_out", out, o);
    chk("lit_c_out", c_out, co);
    chk("lit_zero", zero, z);
    chk("lit_negative", negative, n);
    chk("lit_overflow", overflow, ov);
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst_n && ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got 1 expected 0 at %0t", $time);
      end else begin
        ce = q.pop_front();
        chk("out", out, ce.res);
        chk("c_out", c_out, ce.co);
        chk("zero", zero, ce.z);
        chk("negative", negative, ce.n);
        chk("overflow", overflow, ce.ov);
        chk("latency", ncyc - ce.cyc, 3);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  // Starts at negedge+1 of a cycle where the DUT can accept; returns in the ready cycle.
  task automatic run_op(logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci, bit hold);
    exp_t e = model(8, m, a, b, ci);
    int t = 0;
    e.cyc = ncyc;
    q.push_back(e);
    mode = m; A = a; B = b; c_in = ci; en = 1'b1;
    @(negedge clk); #1;
    chk("busy_in_calc", busy, 1);
    while (!ready && t < 20) begin
      en = hold;
      A = 8'($urandom); B = 8'($urandom); mode = 2'($urandom); c_in = 1'($urandom);
      @(negedge clk); #1;
      t++;
    end
    en = 1'b0;
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_ready: got 0 expected 1 at %0t", $time);
      q.delete();
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic run16(logic [1:0] m, logic [15:0] a, logic [15:0] b, logic ci);
    exp_t e = model(16, m, a, b, ci);
    int t = 0;
    mode16 = m; A16 = a; B16 = b; c16 = ci; en16 = 1'b1;
    @(negedge clk); #1;
    en16 = 1'b0;
    A16 = 16'($urandom); B16 = 16'($urandom);
    while (!ready16 && t < 30) begin
      @(negedge clk); #1;
      t++;
    end
    chk("latency16", t, 4);
    chk("out16", out16, e.res);
    chk("c_out16", c_out16, e.co);
    chk("zero16", zero16, e.z);
    chk("negative16", negative16, e.n);
    chk("overflow16", overflow16, e.ov);
    @(negedge clk); #1;
    chk("ready16_pulse", ready16, 0);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] c [4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
    return $urandom_range(0, 3) == 0 ? c[$urandom_range(0, 3)] : 8'($urandom);
  endfunction

  initial begin
    #1;
    chk("rst_out", out, 0);
    chk("rst_flags", {c_out, zero, negative, overflow}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    run_op(2'd0, 8'h01, 8'h02, 1'b1, 0);
    chkd(8'h03, 0, 0, 0, 0);
    idle(1);
    chk("ready_pulse", ready, 0);
    run_op(2'd0, 8'hFF, 8'h01, 1'b0, 0);
    chkd(8'h00, 1, 1, 0, 0);
    idle(1);
    run_op(2'd1, 8'h80, 8'h01, 1'b0, 0);
    chkd(8'h7F, 1, 0, 0, 1);
    run_op(2'd3, 8'h00, 8'h00, 1'b1, 0);
    chkd(8'hFF, 0, 0, 1, 0);
    idle(1);
    run_op(2'd2, 8'h7F, 8'h00, 1'b1, 0);
    chkd(8'h80, 0, 0, 1, 1);
    idle(1);
    run_op(2'd0, 8'h10, 8'h20, 1'b0, 1);
    chkd(8'h30, 0, 0, 0, 0);
    idle(2);
    mode = 2'd0; A = 8'h33; B = 8'h44; en = 1'b1;
    @(negedge clk); #1;
    en = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_flags", {c_out, zero, negative, overflow}, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", ready, 0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    chk("no_ready_after_abort", ready, 0);
    run_op(2'd0, 8'h05, 8'h03, 1'b0, 0);
    chkd(8'h08, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      run_op(2'($urandom), pick8(), pick8(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    run16(2'd0, 16'h00FF, 16'h0001, 1'b0);
    chk("lit_out16", out16, 16'h0100);
    for (int i = 0; i < 20; i++) run16(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cla_alu_seq.md
Name: cla_alu_seq

Overview:
- Parametrised, multi-cycle add/subtract unit. It is the successor of the 4-bit cla_adder used by the 8-bit datapath.
- Each cycle it processes one BLOCK-bit slice through a carry-lookahead slice. The carry ripples slice-to-slice through a register.
- Adds subtract and carry/borrow-chained modes, plus status flags, behind an en/ready handshake.
- Feeds the accumulator and the flags register of the CPU core.

Parameters:
- WIDTH, 8, operand/result width. Must be a multiple of BLOCK and at least BLOCK.
- BLOCK, 4, bits per CLA slice, i.e. bits processed per cycle.
- NSLICE (localparam), WIDTH/BLOCK, slices per operation. Not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled on rising clk.
- mode  in  2  operation: 0 ADD, 1 SUB, 2 ADC, 3 SBB.
- c_in  in  1  carry in (ADC) or borrow in (SBB); ignored for ADD/SUB.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Output  out  WIDTH  result.
- c_out  out  1  carry out of the MSB.
- zero  out  1  Output == 0.
- negative  out  1  Output[WIDTH-1].
- overflow  out  1  signed overflow.
- busy  out  1  operation in progress.
- ready  out  1  one-cycle pulse: result and flags valid.

Behaviour:
- Reset: rst_n low forces the following immediately, independent of clk:
  - state = IDLE;
  - Output, c_out, zero, negative, overflow, busy, ready = 0;
  - internal slice index, carry register and operand registers = 0.
- Reset mid-operation aborts the operation; no ready pulse is produced for it.
- States: IDLE, CALC, DONE.
- IDLE: en=1 at an edge (the acceptance edge) does all of the following:
  - latch A, and latch B or ~B for SUB/SBB;
  - set carry register: ADD 0, SUB 1, ADC c_in, SBB ~c_in;
  - set slice index = 0 and go to CALC. busy=1 from this edge.
- SBB semantics: result = A - B - c_in.
- CALC: each edge does the following for slice i (bits i*BLOCK+BLOCK-1 .. i*BLOCK):
  - compute the slice sum from latched A, latched B and the carry register;
  - write the slice into Output and update the carry register with the slice carry-out;
  - increment i.
- Last CALC edge (i = NSLICE-1):
  - c_out = final carry;
  - overflow = carry into MSB XOR carry out of MSB;
  - zero and negative are computed from the full new Output;
  - go to DONE, busy=0, ready=1.
- Latency: ready is high in the cycle following edge NSLICE after the acceptance edge (WIDTH=8, BLOCK=4: 2 cycles).
- DONE: ready=1 for exactly one cycle, then ready=0.
  - en=1 at this edge: a new operation is accepted (identical to IDLE acceptance), giving back-to-back throughput of one result per NSLICE+1 cycles.
  - Otherwise go to IDLE.
- en while busy (CALC): ignored. Operands are not re-latched and there is no queueing.
- Output and flags are updated slice-by-slice during CALC. They are valid only when ready=1, and held stable from DONE until the next acceptance edge.
- SUB/SBB c_out follows the 6502 convention: 1 = no borrow.
- No arithmetic on inputs outside the acceptance edge. A, B, mode and c_in may change freely while busy.
- All flag and result widths are exact. No sign extension; carry beyond MSB appears only on c_out.

Test Plan:
1. WIDTH=8, mode=ADD, A=8'h01, B=8'h02, c_in=1, one-cycle en pulse -> ready high in 2nd cycle after acceptance; Output=8'h03, c_out=0, zero=0, overflow=0 (c_in ignored).
2. ADD, A=8'hFF, B=8'h01 -> Output=8'h00, c_out=1, zero=1, overflow=0, negative=0.
3. SUB, A=8'h80, B=8'h01 -> Output=8'h7F, c_out=1, overflow=1, negative=0. Then, back-to-back with en held in DONE: SBB, A=8'h00, B=8'h00, c_in=1 -> Output=8'hFF, c_out=0, negative=1, overflow=0.
4. ADC, A=8'h7F, B=8'h00, c_in=1 -> Output=8'h80, overflow=1, negative=1, c_out=0. Then, re-elaborated with WIDTH=16: ADD 16'h00FF+16'h0001 -> Output 16'h0100, ready 4 cycles after acceptance.
5. Accept ADD 8'h10+8'h20. Then, during CALC, hold en=1 and change A=8'hAA, B=8'h55 -> first result 8'h30 with a single ready pulse; A/B changes have no effect.
6. Assert rst_n=0 asynchronously mid-CALC -> all outputs 0 before the next edge and no ready pulse. Release, then ADD 8'h05+8'h03 -> Output=8'h08, ready after 2 cycles.
